// File: rtl/ahb_dma_master.sv
// AHB-Lite block-copy initiator.
// One SINGLE read then one SINGLE write per word.
module ahb_dma_master #(
  parameter int          LEN_W     = 16,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_done,
  output logic [31:0]      ahb_haddr_o,
  output logic             ahb_hwrite_o,
  output logic [2:0]       ahb_hsize_o,
  output logic [2:0]       ahb_hburst_o,
  output logic [3:0]       ahb_hprot_o,
  output logic [1:0]       ahb_htrans_o,
  output logic             ahb_hmastlock_o,
  output logic [31:0]      ahb_hwdata_o,
  input  logic             ahb_hready_i,
  input  logic             ahb_hresp_i,
  input  logic [31:0]      ahb_hrdata_i
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, FINISH
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [31:0]      cur_src;
  logic [31:0]      cur_dst;
  logic [31:0]      rbuf;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic             err_q;
  logic             accept;

  assign cnt_inc = cnt + 1'b1;
  assign accept  = (state == IDLE) && start;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; address phases hold until hready
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start)
          state_nx = (len == '0) ? FINISH : RD_ADDR;
      RD_ADDR:
        if (ahb_hready_i) state_nx = RD_DATA;
      RD_DATA:
        if (ahb_hready_i)
          state_nx = ahb_hresp_i ? FINISH : WR_ADDR;
      WR_ADDR:
        if (ahb_hready_i) state_nx = WR_DATA;
      WR_DATA:
        if (ahb_hready_i) begin
          if (ahb_hresp_i)          state_nx = FINISH;
          else if (cnt_inc == len_q) state_nx = FINISH;
          else                       state_nx = RD_ADDR;
        end
      FINISH:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // Datapath: latch job, capture read data, advance pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_src <= '0;
      cur_dst <= '0;
      rbuf    <= '0;
      len_q   <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cur_src <= {src_addr[31:2], 2'b00};
        cur_dst <= {dst_addr[31:2], 2'b00};
        len_q   <= len;
        cnt     <= '0;
        err_q   <= 1'b0;
      end
      if (state == RD_DATA && ahb_hready_i) begin
        if (ahb_hresp_i) err_q <= 1'b1;
        else             rbuf  <= ahb_hrdata_i;
      end
      if (state == WR_DATA && ahb_hready_i) begin
        if (ahb_hresp_i) begin
          err_q <= 1'b1;
        end else begin
          cnt     <= cnt_inc;
          cur_src <= cur_src + 32'd4;
          cur_dst <= cur_dst + 32'd4;
        end
      end
    end
  end

  // Bus outputs decode from registered state only
  always_comb begin
    ahb_hwrite_o = (state == WR_ADDR) || (state == WR_DATA);
    ahb_htrans_o = ((state == RD_ADDR) || (state == WR_ADDR))
                   ? 2'b10 : 2'b00;
    ahb_haddr_o  = ahb_hwrite_o ? cur_dst : cur_src;
  end

  assign ahb_hwdata_o    = rbuf;
  assign ahb_hsize_o     = 3'b010;
  assign ahb_hburst_o    = 3'b000;
  assign ahb_hprot_o     = HPROT_VAL;
  assign ahb_hmastlock_o = 1'b0;
  assign busy            = (state != IDLE);
  assign done            = (state == FINISH);
  assign error           = err_q;
  assign words_done      = cnt;

endmodule

// File: doc/ahb_dma_master.md
Name: ahb_dma_master

Overview:
- AHB-Lite initiator (bus master) that copies a block of 32-bit words from a source address to a destination address. Each word is one single read followed by one single write.
- Sits alongside cpu_core as a second initiator. It is intended to move camera or NPU buffers without CPU load.
- It drives the same AHB signal set the CPU drives into the interconnect, and uses a simple start/done control port.

Parameters:
- LEN_W, 16, width of the word-count input and the progress counter.
- HPROT_VAL, 4'b0011, constant driven on ahb_hprot_o.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- src_addr  in  32  source byte address; bits [1:0] are ignored (treated as 0).
- dst_addr  in  32  destination byte address; bits [1:0] are ignored.
- len  in  LEN_W  number of words to copy.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at the end of a transfer.
- error  out  1  sticky error flag; cleared by an accepted start.
- words_done  out  LEN_W  number of words fully written.
- ahb_haddr_o  out  32  address.
- ahb_hwrite_o  out  1  1 = write.
- ahb_hsize_o  out  3  constant 3'b010 (word).
- ahb_hburst_o  out  3  constant 3'b000 (SINGLE).
- ahb_hprot_o  out  4  constant HPROT_VAL.
- ahb_htrans_o  out  2  2'b00 IDLE or 2'b10 NONSEQ.
- ahb_hmastlock_o  out  1  constant 0.
- ahb_hwdata_o  out  32  write data.
- ahb_hready_i  in  1  transfer ready.
- ahb_hresp_i  in  1  1 = ERROR response.
- ahb_hrdata_i  in  32  read data.

Behaviour:
- Reset values:
  - state IDLE; busy=0; done=0; error=0; words_done=0.
  - htrans=IDLE, haddr=0, hwrite=0, hwdata=0.
  - Read buffer and internal address registers = 0.
- Reset is synchronous and takes effect on any cycle, including mid-transfer. It forces IDLE and htrans=IDLE on the next edge. Because the bus reset is system-wide, no completion of an in-flight beat is attempted.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, FINISH.
- Transfers are non-pipelined: the next address phase is never issued during a data phase.
- IDLE:
  - On start=1: latch src/dst (low 2 bits forced to 0) and len; clear error and words_done.
  - If len=0, go to FINISH (no bus activity); otherwise go to RD_ADDR.
- RD_ADDR:
  - Drive htrans=NONSEQ, hwrite=0, haddr=cur_src.
  - Hold all signals until hready_i=1 is sampled, then go to RD_DATA.
- RD_DATA:
  - Drive htrans=IDLE and wait for hready_i=1.
  - On hready_i=1 with hresp_i=0: capture hrdata_i into the buffer and go to WR_ADDR.
  - On hready_i=1 with hresp_i=1 (second cycle of an ERROR response): set error=1 and go to FINISH.
- WR_ADDR:
  - Drive htrans=NONSEQ, hwrite=1, haddr=cur_dst.
  - Hold until hready_i=1, then go to WR_DATA.
- WR_DATA:
  - Drive htrans=IDLE; hwdata_o = buffer, held stable until hready_i=1.
  - On hready_i=1 with hresp_i=1: set error=1 and go to FINISH. words_done is not incremented.
  - On hready_i=1 with hresp_i=0: words_done+1, cur_src+4, cur_dst+4 (modulo 2^32, wrap allowed).
  - Then go to FINISH if words_done+1 == len, else go to RD_ADDR.
- FINISH: done=1 for exactly one cycle, then go to IDLE.
- start while busy is ignored. start during FINISH is also ignored.
- Latency with a zero-wait slave, start sampled at edge k:
  - First NONSEQ is visible in cycle k+1.
  - Each word takes 4 cycles.
  - done is high in cycle k+1+4*len, or k+1 when len=0.
  - Each wait state adds one cycle.
- An ERROR response in the first error cycle (hready_i=0, hresp_i=1) is treated as a wait state.
- Outputs are registered; no combinational path from AHB inputs to AHB outputs.

Test Plan:
- Zero-wait copy: src=0x1000, dst=0x2000, len=3; slave returns 0xA0,0xA1,0xA2 -> writes to 0x2000/4/8 with the same data; done at cycle k+13; words_done=3; error=0.
- Wait states: len=1, slave inserts 2 wait cycles in each phase -> haddr, hwrite and hwdata stay stable while hready_i=0; done at cycle k+9.
- Read error: len=4, second read gets ERROR -> error=1, words_done=1, exactly one write issued, one done pulse, busy falls one cycle later.
- len=0 and misaligned address: start with len=0 -> done at k+1, htrans stays IDLE. start with src=0x1003, len=1 -> haddr=0x1000.
- Address wrap: dst=0xFFFFFFFC, len=2 -> second write goes to 0x00000000.
- Reset and start while busy: start pulse in RD_DATA is ignored (counters unchanged). reset asserted in WR_DATA -> next cycle state IDLE, htrans=IDLE, busy=0, words_done=0.
